// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller for the 5-stage core: Tuse/Tnew data-hazard detection,
// MDU busy sequencing for HI/LO-class instructions, and a saturating stall counter.
module hazard_stall_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       D_rs,
  input  logic [4:0]       D_rt,
  input  logic [1:0]       D_tuse_rs,
  input  logic [1:0]       D_tuse_rt,
  input  logic             D_md,
  input  logic [4:0]       E_wa,
  input  logic [1:0]       E_tnew,
  input  logic [4:0]       M_wa,
  input  logic [1:0]       M_tnew,
  input  logic             E_md_start,
  input  logic             E_md_div,
  output logic             stall,
  output logic             PC_en,
  output logic             FD_en,
  output logic             DE_flush,
  output logic             md_busy,
  output logic             md_done,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [3:0] MULT_LD = 4'(MULT_CYC);
  localparam logic [3:0] DIV_LD  = 4'(DIV_CYC);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q;
  logic [3:0]       cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [3:0]       load_val;

  logic stall_rs, stall_rt, stall_md;

  // A source stalls only when a producer's result arrives later than D needs it; $0 is never a hazard.
  assign stall_rs = (D_rs != 5'd0) &&
                    (((D_rs == E_wa) && (E_tnew > D_tuse_rs)) ||
                     ((D_rs == M_wa) && (M_tnew > D_tuse_rs)));
  assign stall_rt = (D_rt != 5'd0) &&
                    (((D_rt == E_wa) && (E_tnew > D_tuse_rt)) ||
                     ((D_rt == M_wa) && (M_tnew > D_tuse_rt)));
  assign stall_md = D_md && (E_md_start || busy_q);

  assign stall    = stall_rs || stall_rt || stall_md;
  assign PC_en    = ~stall;
  assign FD_en    = ~stall;
  assign DE_flush = stall;

  assign md_busy   = busy_q;
  assign md_done   = done_q;
  assign stall_cnt = stall_cnt_q;

  assign load_val = E_md_div ? DIV_LD : MULT_LD;

  // MDU sequencer: busy/done are registered alongside the down-counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (E_md_start) begin
            state_q <= BUSY;
            cnt_q   <= load_val;
            busy_q  <= 1'b1;
            done_q  <= (load_val == 4'd1);
          end
        end
        BUSY: begin
          if (cnt_q == 4'd1) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end else begin
            cnt_q   <= cnt_q - 4'd1;
            busy_q  <= 1'b1;
            done_q  <= (cnt_q == 4'd2);
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= 4'd0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline hazard and multiply/divide sequencing controller for the 5-stage MIPS core. It compares the D-stage operand demand (Tuse) against the E- and M-stage result supply (Tnew) and generates the stall, hold and bubble controls for PC, the F/D register and the D/E register. It also owns the multiply/divide unit (MDU) busy sequencer, which stalls any HI/LO-class instruction in D while the MDU is occupied. A saturating stall counter is kept for performance checks.

## Interface
Parameters:
- MULT_CYC, 5, busy cycles for mult/multu
- DIV_CYC, 10, busy cycles for div/divu
- CNT_W, 16, width of stall counter

Ports:
- clk  in  1  clock, all state updates on posedge
- reset  in  1  reset, synchronous, active-high
- D_rs  in  5  rs register number of D instruction
- D_rt  in  5  rt register number of D instruction
- D_tuse_rs  in  2  cycles until rs is needed (3 = not used)
- D_tuse_rt  in  2  cycles until rt is needed (3 = not used)
- D_md  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo
- E_wa  in  5  destination register of E instruction (0 = none)
- E_tnew  in  2  cycles until E result is available
- M_wa  in  5  destination register of M instruction (0 = none)
- M_tnew  in  2  cycles until M result is available
- E_md_start  in  1  E instruction is mult/multu/div/divu
- E_md_div  in  1  1 = divide, 0 = multiply; valid with E_md_start
- stall  out  1  D instruction must wait this cycle
- PC_en  out  1  ~stall
- FD_en  out  1  ~stall
- DE_flush  out  1  = stall; D/E register loads a bubble (instr 0)
- md_busy  out  1  MDU occupied
- md_done  out  1  one-cycle pulse in last busy cycle
- stall_cnt  out  CNT_W  number of stalled cycles since reset, saturating

## Operation
- Data stall (combinational): stall_rs = (D_rs != 0) & ((D_rs == E_wa & E_tnew > D_tuse_rs) | (D_rs == M_wa & M_tnew > D_tuse_rs)); stall_rt identical with D_rt/D_tuse_rt. Register 0 never stalls.
- MDU stall: stall_md = D_md & (E_md_start | md_busy).
- stall = stall_rs | stall_rt | stall_md.
- MDU sequencer, states IDLE and BUSY, backed by a 4-bit down-counter cnt:
  - IDLE: if E_md_start at posedge then load cnt = DIV_CYC when E_md_div, else MULT_CYC. Go to BUSY.
  - BUSY: cnt decrements each cycle. When cnt == 1 at posedge, go to IDLE (cnt = 0).
  - E_md_start while BUSY is ignored. Stall logic makes this unreachable and the bench flags it.
- md_busy = (cnt != 0); md_done = (cnt == 1).
- stall_cnt increments by 1 on each posedge where stall == 1. It holds at 2^CNT_W−1.
- Stall does not freeze the MDU counter. The bubble inserted into E carries E_md_start = 0.

## Timing
- Reset (synchronous, sampled at posedge): state IDLE, cnt = 0, stall_cnt = 0, md_busy = 0, md_done = 0. stall, PC_en, FD_en and DE_flush then follow the combinational inputs.
- stall, PC_en, FD_en and DE_flush are purely combinational, with zero-cycle latency from inputs.
- MDU start: mult sampled at edge t0 gives md_busy = 1 for cycles t0+1 … t0+5, with md_done during t0+5. md_busy = 0 from t0+6. Divide uses 10 cycles (t0+1 … t0+10).
- A D-stage HI/LO instruction sitting behind a mult in E stalls for 1 + MULT_CYC = 6 cycles. It advances in the cycle where md_busy first reads 0.
- Back-to-back: a new E_md_start in the cycle right after the last busy cycle is accepted normally.
- A reset asserted mid-BUSY aborts the operation: md_busy = 0 next cycle, with no md_done pulse.
- A simultaneous data stall and MDU stall still count as 1 stall cycle.

## Test plan
- Load-use: E_wa = 8, E_tnew = 2, D_rs = 8, D_tuse_rs = 1 -> stall = 1, PC_en = FD_en = 0, DE_flush = 1. With M_wa = 8, M_tnew = 1, D_tuse_rs = 1 and E_wa = 0 -> stall = 0.
- $0 immunity: E_wa = 0, E_tnew = 2, D_rs = 0, D_tuse_rs = 0 -> stall = 0. stall_cnt is unchanged.
- mult then mflo: E_md_start = 1, E_md_div = 0 at t0, with D_md = 1 held -> stall = 1 for exactly 6 cycles. md_done pulses in cycle t0+5. stall_cnt = 6.
- div: E_md_start = 1, E_md_div = 1 -> md_busy high for exactly 10 cycles. md_done is high only in the 10th.
- Reset mid-div: assert reset in busy cycle 4 -> md_busy = 0, md_done = 0 and stall_cnt = 0 next cycle. The following mult is accepted normally.
- Saturation (CNT_W = 4): hold stall for 20 cycles -> stall_cnt reaches 15 and stays at 15.
